// File: rtl/pc_redirect_unit.sv
// Fetch PC register and next-PC selector with stall-safe redirect holding.
// Optional branch statistics counters are enabled by defining BR_STAT_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef BR_STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_d,
    input  logic        br_ne_d,
    input  logic        cmp_eq_d,
    input  logic [15:0] imm16_d,
    input  logic        j_d,
    input  logic [25:0] idx26_d,
    input  logic        jr_d,
    input  logic [31:0] jr_tgt_d,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        taken_q,
    output logic        misalign_q
`ifdef BR_STAT_EN
    ,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_total_cnt
`endif
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt_q;
    logic        br_redir_s;
    logic        redir_s;
    logic [31:0] br_off_s;
    logic [31:0] tgt_s;

    // Redirect decision and target selection, jr > j > branch
    always_comb begin
        br_redir_s = br_d & (cmp_eq_d ^ br_ne_d);
        redir_s    = jr_d | j_d | br_redir_s;
        br_off_s   = {{14{imm16_d[15]}}, imm16_d, 2'b00};
        if (jr_d) begin
            tgt_s = {jr_tgt_d[31:2], 2'b00};
        end else if (j_d) begin
            tgt_s = {pc_d[31:28], idx26_d, 2'b00};
        end else begin
            tgt_s = pc_d + 32'd4 + br_off_s;
        end
    end

    // PC register and RUN/HOLD control; HOLD remembers a redirect made while stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            pend_tgt_q <= 32'h0000_0000;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (jr_d && (jr_tgt_d[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        pc_q    <= redir_s ? tgt_s : (pc_q + 32'd4);
                        taken_q <= redir_s;
                    end else begin
                        taken_q <= 1'b0;
                        if (redir_s) begin
                            pend_tgt_q <= tgt_s;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stall) begin
                        taken_q <= 1'b0;
                        // A re-evaluated decision carries fresher forwarded operands
                        if (redir_s) begin
                            pend_tgt_q <= tgt_s;
                        end
                    end else begin
                        pc_q    <= redir_s ? tgt_s : pend_tgt_q;
                        taken_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    taken_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_f  = pc_q;
    assign pc4_f = pc_q + 32'd4;

`ifdef BR_STAT_EN
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] total_cnt_q;

    // Saturating branch statistics, counted only on cycles where pc_f loads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_cnt_q <= '0;
            total_cnt_q <= '0;
        end else if (!stall && br_d) begin
            if (total_cnt_q != {CNT_W{1'b1}}) begin
                total_cnt_q <= total_cnt_q + CNT_W'(1);
            end
            if (br_redir_s && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign br_taken_cnt = taken_cnt_q;
    assign br_total_cnt = total_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed table-driven bench for pc_redirect_unit plus hold/reset/statistics sequences.
// Statistics checks are compiled in when BR_STAT_EN is defined.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset_n, stall, br_d, br_ne_d, cmp_eq_d, j_d, jr_d;
    logic [15:0] imm16_d;
    logic [25:0] idx26_d;
    logic [31:0] jr_tgt_d, pc_d, pc_f, pc4_f;
    logic        taken_q, misalign_q;
    int          checks = 0;
    int          errors = 0;

`ifdef BR_STAT_EN
    localparam int CW = 3;
    logic [CW-1:0] tk_cnt, tot_cnt;
`endif

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC(32'h0000_3000)
`ifdef BR_STAT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_d(br_d), .br_ne_d(br_ne_d),
        .cmp_eq_d(cmp_eq_d), .imm16_d(imm16_d), .j_d(j_d), .idx26_d(idx26_d),
        .jr_d(jr_d), .jr_tgt_d(jr_tgt_d), .pc_d(pc_d), .pc_f(pc_f), .pc4_f(pc4_f),
        .taken_q(taken_q), .misalign_q(misalign_q)
`ifdef BR_STAT_EN
        , .br_taken_cnt(tk_cnt), .br_total_cnt(tot_cnt)
`endif
    );

    typedef struct {
        logic        stall, br, ne, eq;
        logic [15:0] imm;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jrt, pcd, exp_pc;
        logic        exp_tk, exp_mis;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic st, logic br, logic ne, logic eq, logic [15:0] imm,
                                logic j, logic [25:0] idx, logic jr, logic [31:0] jrt,
                                logic [31:0] pcd, logic [31:0] epc, logic etk, logic emis);
        vec_t v;
        v.stall = st; v.br = br; v.ne = ne; v.eq = eq; v.imm = imm;
        v.j = j; v.idx = idx; v.jr = jr; v.jrt = jrt; v.pcd = pcd;
        v.exp_pc = epc; v.exp_tk = etk; v.exp_mis = emis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; br_d = 1'b0; br_ne_d = 1'b0; cmp_eq_d = 1'b0; imm16_d = 16'h0000;
        j_d = 1'b0; idx26_d = 26'h000_0000; jr_d = 1'b0; jr_tgt_d = 32'h0000_0000;
        pc_d = 32'h0000_0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string name, input logic [31:0] epc, input logic etk,
                            input logic emis);
        check({name, ".pc_f"}, pc_f, epc);
        check({name, ".pc4_f"}, pc4_f, epc + 32'd4);
        check({name, ".taken"}, {31'd0, taken_q}, {31'd0, etk});
        check({name, ".misalign"}, {31'd0, misalign_q}, {31'd0, emis});
    endtask

`ifdef BR_STAT_EN
    task automatic check_cnt(input string name, input int etot, input int etk);
        check({name, ".total"}, 32'(tot_cnt), 32'(etot));
        check({name, ".taken_cnt"}, 32'(tk_cnt), 32'(etk));
    endtask
`endif

    initial begin
        //             st    br    ne    eq    imm       j     idx          jr    jrt            pcd            exp_pc         tk    mis
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3004, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3008, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_300C, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_3004, 32'h0000_3014, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_3004, 32'h0000_3018, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_3018, 32'h0000_3018, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0400, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0404, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 26'h000_0100, 1'b1, 32'h0000_3027, 32'h0000_0000, 32'h0000_3024, 1'b1, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3028, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3028, 1'b0, 1'b1);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_1000, 32'h0000_3028, 1'b0, 1'b1);
        vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h000_0040, 1'b0, 32'h0000_0000, 32'h0000_1000, 32'h0000_3028, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b1);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0200, 32'h0000_0100, 1'b0, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b1, 32'h0000_5000, 32'h0000_0000, 32'h0000_5000, 1'b1, 1'b1);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_5004, 1'b0, 1'b1);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0000_0000, 32'hF000_0000, 32'hFFFF_FFFC, 1'b1, 1'b1);

        // Reset with misaligned jr and jump asserted: reset must win
        idle();
        reset_n = 1'b0; jr_d = 1'b1; jr_tgt_d = 32'h0000_3027; j_d = 1'b1; idx26_d = 26'h000_0100;
        step();
        check_pc("reset", 32'h0000_3000, 1'b0, 1'b0);
`ifdef BR_STAT_EN
        check_cnt("reset", 0, 0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            stall = vecs[i].stall; br_d = vecs[i].br; br_ne_d = vecs[i].ne; cmp_eq_d = vecs[i].eq;
            imm16_d = vecs[i].imm; j_d = vecs[i].j; idx26_d = vecs[i].idx; jr_d = vecs[i].jr;
            jr_tgt_d = vecs[i].jrt; pc_d = vecs[i].pcd;
            step();
            check_pc($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_tk, vecs[i].exp_mis);
        end
`ifdef BR_STAT_EN
        check_cnt("table", 5, 4);
`endif

        // Taken branch held by a 4-cycle stall is applied and counted once
        idle();
        stall = 1'b1; br_d = 1'b1; cmp_eq_d = 1'b1; imm16_d = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            step();
            check_pc($sformatf("hold%0d", i), 32'hFFFF_FFFC, 1'b0, 1'b1);
`ifdef BR_STAT_EN
            check_cnt($sformatf("hold%0d", i), 5, 4);
`endif
        end
        stall = 1'b0;
        step();
        check_pc("release", 32'h0000_0014, 1'b1, 1'b1);
`ifdef BR_STAT_EN
        check_cnt("release", 6, 5);
`endif

        // Not-taken branches push the total counter into saturation
        cmp_eq_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc($sformatf("nt%0d", i), 32'h0000_0018 + 32'(4 * i), 1'b0, 1'b1);
`ifdef BR_STAT_EN
            check_cnt($sformatf("nt%0d", i), 7, 5);
`endif
        end

        // Taken bne branches push the taken counter into saturation
        br_ne_d = 1'b1; imm16_d = 16'h0000; pc_d = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc($sformatf("tk%0d", i), 32'h0000_0104, 1'b1, 1'b1);
`ifdef BR_STAT_EN
            check_cnt($sformatf("tk%0d", i), 7, (i == 0) ? 6 : 7);
`endif
        end

        // Reset while a redirect is pending must discard it
        idle();
        stall = 1'b1; j_d = 1'b1; idx26_d = 26'h000_0010;
        step();
        check_pc("pend", 32'h0000_0104, 1'b0, 1'b1);
        reset_n = 1'b0;
        step();
        check_pc("rst_hold", 32'h0000_3000, 1'b0, 1'b0);
`ifdef BR_STAT_EN
        check_cnt("rst_hold", 0, 0);
`endif
        reset_n = 1'b1;
        idle();
        step();
        check_pc("post_rst", 32'h0000_3004, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
